timestamp_tagger: RTL

TIMESTAMP_TAGGER -- requirements
Module: timestamp_tagger

---
 rtl/timestamp_pkg.sv | 19 +
 rtl/timestamp_tagger_fifo.sv | 53 +++++
 rtl/timestamp_tagger.sv | 91 +++++++++
 3 files changed

// File: rtl/timestamp_pkg.sv
// Timestamp word layout shared by the tagger and the receive-side unwrap logic.
// Field positions are expressed relative to the payload width.
package timestamp_pkg;

    localparam int TS_W = 8;

    function automatic int TS_LSB(input int data_w);
        return data_w;
    endfunction

    function automatic int IS_MARKER_BIT(input int data_w);
        return data_w + TS_W;
    endfunction

    function automatic int TX_W(input int data_w);
        return data_w + TS_W + 1;
    endfunction

endpackage

// File: rtl/timestamp_tagger_fifo.sv
// Synchronous show-ahead FIFO whose read word comes straight from storage flops.
// Pushes when full and pops when empty are ignored.
module timestamp_tagger_fifo #(
    parameter int W     = 25,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == L_DEPTH);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_rdata = r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + {{AW{1'b0}}, w_push}
                               - {{AW{1'b0}}, w_pop};
        end
    end

endmodule

// File: rtl/timestamp_tagger.sv
// Tags samples with an 8-bit tick timestamp and inserts marker words
// during idle stretches so the receiver can unwrap the timestamp.
module timestamp_tagger
    import timestamp_pkg::*;
#(
    parameter int DATA_W          = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int MARKER_INTERVAL = 128
) (
    input  logic              clk_128M,
    input  logic              reset_128M,
    input  logic              ts_clk_edge_128M,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic [DATA_W+8:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        stall_count
);
    localparam int L_TX_W   = TX_W(DATA_W);
    localparam int L_TS_LSB = TS_LSB(DATA_W);
    localparam int L_MARK   = IS_MARKER_BIT(DATA_W);
    localparam logic [TS_W-1:0] L_MI = TS_W'(MARKER_INTERVAL);

    logic [TS_W-1:0]   r_ts;
    logic [TS_W-1:0]   r_idle;
    logic [7:0]        r_stall;
    logic              w_full;
    logic              w_empty;
    logic              w_sample_push;
    logic              w_marker_pend;
    logic              w_marker_push;
    logic              w_push;
    logic [L_TX_W-1:0] w_word;

    assign sample_ready  = ~w_full & ~reset_128M;
    assign w_sample_push = sample_valid & sample_ready;
    assign w_marker_pend = (r_idle == L_MI);
    assign w_marker_push = w_marker_pend & ~w_full
                         & ~w_sample_push & ~reset_128M;
    assign w_push        = w_sample_push | w_marker_push;
    assign tx_valid      = ~w_empty;
    assign stall_count   = r_stall;

    always_comb begin
        w_word = '0;
        w_word[L_MARK] = w_marker_push;
        w_word[L_MARK-1:L_TS_LSB] = r_ts;
        if (!w_marker_push) begin
            w_word[DATA_W-1:0] = sample_data;
        end
    end

    // Idle tracks ts minus the last pushed timestamp, so a push on a
    // tick cycle restarts it at 1 rather than 0.
    always_ff @(posedge clk_128M) begin
        if (reset_128M) begin
            r_ts    <= '0;
            r_idle  <= '0;
            r_stall <= '0;
        end else begin
            if (ts_clk_edge_128M) begin
                r_ts <= r_ts + 1'b1;
            end
            if (w_push) begin
                r_idle <= TS_W'(ts_clk_edge_128M);
            end else if (ts_clk_edge_128M && !w_marker_pend) begin
                r_idle <= r_idle + 1'b1;
            end
            if (sample_valid && !sample_ready && r_stall != 8'hFF) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

    timestamp_tagger_fifo #(
        .W     (L_TX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_128M),
        .i_rst   (reset_128M),
        .i_push  (w_push),
        .i_wdata (w_word),
        .i_pop   (tx_ready),
        .o_rdata (tx_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
